aes_stream_adapter: RTL and testbench

- Parametrised word-serial front/back end for the AES core.
- Assembles WORD_W-wide key and text beats into a KEY_W-bit key and a 128-bit block, then issues a one-cycle load to the core.
- Waits for core done, then serialises the 128-bit result back out over a valid/ready stream.
- Generalises the fixed 32-bit ld/key/text_in loading to configurable word width and key length, with handshaked backpressure on both sides.

---
 rtl/aes_stream_adapter_pkg.sv | 32 +++
 rtl/aes_stream_adapter_word_shreg.sv | 27 ++
 rtl/aes_stream_adapter.sv | 179 +++++++++++++++++
 tb/tb_aes_stream_adapter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_adapter_pkg.sv
// Shared types and derived beat counts for the AES word-serial stream adapter.
package aes_adapt_pkg;

   typedef enum logic [1:0] {S_FILL, S_LD, S_WAIT, S_DRAIN} state_t;

   localparam int BLOCK_W = 128;

   function automatic int txt_beats(input int word_w);
      return BLOCK_W / word_w;
   endfunction

   function automatic int key_beats(input int word_w, input int key_w);
      return key_w / word_w;
   endfunction

   function automatic int in_beats(input int word_w, input int key_w);
      int t;
      int k;
      t = txt_beats(word_w);
      k = key_beats(word_w, key_w);
      return (t > k) ? t : k;
   endfunction

   function automatic bit params_legal(input int word_w, input int key_w);
      bit w_ok;
      bit k_ok;
      w_ok = (word_w == 8) || (word_w == 16) || (word_w == 32) || (word_w == 64);
      k_ok = (key_w == 128) || (key_w == 192) || (key_w == 256);
      return w_ok && k_ok && ((key_w % word_w) == 0);
   endfunction

endpackage

// File: rtl/aes_stream_adapter_word_shreg.sv
// Word-granular shift register: parallel load, shift-in at the LSW end, MSW leaves first.
module aes_word_shreg
   import aes_adapt_pkg::*;
#(
   parameter int WIDTH  = 128,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_data,
   input  logic              shift_en,
   input  logic [WORD_W-1:0] shift_in,
   output logic [WIDTH-1:0]  q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift_en) begin
         q <= {q[WIDTH-WORD_W-1:0], shift_in};
      end
   end

endmodule

// File: rtl/aes_stream_adapter.sv
// Word-serial key/text loader and result serialiser around the AES core.
// Optional key caching (key_reload port) is enabled by defining AES_ADAPT_KEY_CACHE_EN.
module aes_stream_adapter
   import aes_adapt_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int KEY_W  = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_key,
   input  logic [WORD_W-1:0] in_text,
   output logic              core_ld,
   output logic [KEY_W-1:0]  core_key,
   output logic [127:0]      core_text,
   input  logic              core_done,
   input  logic [127:0]      core_text_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
`ifdef AES_ADAPT_KEY_CACHE_EN
   ,
   input  logic              key_reload
`endif
);

   localparam int TXT_BEATS = txt_beats(WORD_W);
   localparam int KEY_BEATS = key_beats(WORD_W, KEY_W);
   localparam int IN_BEATS  = in_beats(WORD_W, KEY_W);
   localparam int CNT_W     = $clog2(IN_BEATS + 1);

   localparam logic [CNT_W-1:0] TXT_C  = CNT_W'(TXT_BEATS);
   localparam logic [CNT_W-1:0] KEY_C  = CNT_W'(KEY_BEATS);
   localparam logic [CNT_W-1:0] IN_C   = CNT_W'(IN_BEATS);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TXT_BEATS - 1);

   generate
      if (!params_legal(WORD_W, KEY_W)) begin : g_bad_params
         $error("aes_stream_adapter: illegal WORD_W/KEY_W combination");
      end
   endgenerate

   state_t           state;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] beat_nxt;
   logic [CNT_W-1:0] fill_target;
   logic [127:0]     res_q;
   logic             fill_hs;
   logic             fill_done;
   logic             out_hs;
   logic             skip_key;
   logic             key_shift;
   logic             text_shift;
   logic             res_load;

   // in_ready is registered high exactly in S_FILL, so it alone qualifies a fill beat.
   assign fill_hs   = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign beat_nxt  = beat_cnt + CNT_W'(1);

`ifdef AES_ADAPT_KEY_CACHE_EN
   logic key_valid;
   logic skip_key_q;

   // The reload decision is taken on the first beat and held for the rest of the block.
   assign skip_key = (beat_cnt == '0) ? (!key_reload && key_valid) : skip_key_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_valid  <= 1'b0;
         skip_key_q <= 1'b0;
      end else begin
         if (fill_hs && (beat_cnt == '0)) skip_key_q <= skip_key;
         if (fill_done) key_valid <= 1'b1;
      end
   end
`else
   assign skip_key = 1'b0;
`endif

   assign fill_target = skip_key ? TXT_C : IN_C;
   assign fill_done   = fill_hs && (beat_nxt == fill_target);
   assign key_shift   = fill_hs && !skip_key && (beat_cnt < KEY_C);
   assign text_shift  = fill_hs && (beat_cnt < TXT_C);
   assign res_load    = (state == S_WAIT) && core_done;

   aes_word_shreg #(.WIDTH(KEY_W), .WORD_W(WORD_W)) u_key_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_data ('0),
      .shift_en  (key_shift),
      .shift_in  (in_key),
      .q         (core_key)
   );

   aes_word_shreg #(.WIDTH(128), .WORD_W(WORD_W)) u_text_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_data ('0),
      .shift_en  (text_shift),
      .shift_in  (in_text),
      .q         (core_text)
   );

   aes_word_shreg #(.WIDTH(128), .WORD_W(WORD_W)) u_res_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (res_load),
      .load_data (core_text_out),
      .shift_en  (out_hs),
      .shift_in  ('0),
      .q         (res_q)
   );

   assign out_data = res_q[127 -: WORD_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FILL;
         beat_cnt  <= '0;
         in_ready  <= 1'b1;
         core_ld   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_FILL: begin
               if (fill_hs) begin
                  if (fill_done) begin
                     state    <= S_LD;
                     beat_cnt <= '0;
                     in_ready <= 1'b0;
                     core_ld  <= 1'b1;
                     busy     <= 1'b1;
                  end else begin
                     beat_cnt <= beat_nxt;
                  end
               end
            end
            S_LD: begin
               core_ld <= 1'b0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  state     <= S_DRAIN;
                  beat_cnt  <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (out_hs) begin
                  if (out_last) begin
                     state     <= S_FILL;
                     beat_cnt  <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     beat_cnt <= beat_nxt;
                     out_last <= (beat_nxt == LAST_C);
                  end
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed bench for aes_stream_adapter: 128-bit and 256-bit key instances with a FIPS-197 core stand-in.
module tb_aes_stream_adapter;

   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] BADC = 128'hbadbadbadbadbadbadbadbadbadbad00;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance A: WORD_W=32, KEY_W=128
   logic         a_in_valid = 1'b0;
   logic         a_in_ready;
   logic [31:0]  a_in_key = '0;
   logic [31:0]  a_in_text = '0;
   logic         a_core_ld;
   logic [127:0] a_core_key;
   logic [127:0] a_core_text;
   logic         a_core_done;
   logic [127:0] a_core_text_out;
   logic         a_out_valid;
   logic         a_out_ready = 1'b0;
   logic [31:0]  a_out_data;
   logic         a_out_last;
   logic         a_busy;
   logic         a_spur = 1'b0;
   logic [2:0]   a_pipe = '0;
   logic [127:0] a_res = '0;
`ifdef AES_ADAPT_KEY_CACHE_EN
   logic         a_key_reload = 1'b1;
`endif

   aes_stream_adapter #(.WORD_W(32), .KEY_W(128)) dut_a (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (a_in_valid),
      .in_ready      (a_in_ready),
      .in_key        (a_in_key),
      .in_text       (a_in_text),
      .core_ld       (a_core_ld),
      .core_key      (a_core_key),
      .core_text     (a_core_text),
      .core_done     (a_core_done),
      .core_text_out (a_core_text_out),
      .out_valid     (a_out_valid),
      .out_ready     (a_out_ready),
      .out_data      (a_out_data),
      .out_last      (a_out_last),
      .busy          (a_busy)
`ifdef AES_ADAPT_KEY_CACHE_EN
      ,
      .key_reload    (a_key_reload)
`endif
   );

   always @(posedge clk) begin
      a_pipe <= {a_pipe[1:0], a_core_ld};
      if (a_core_ld) a_res <= (a_core_key == K128 && a_core_text == PT) ? C128 : BADC;
   end
   assign a_core_done     = a_pipe[2] | a_spur;
   assign a_core_text_out = a_res;

   // ---------------- instance B: WORD_W=32, KEY_W=256
   logic         b_in_valid = 1'b0;
   logic         b_in_ready;
   logic [31:0]  b_in_key = '0;
   logic [31:0]  b_in_text = '0;
   logic         b_core_ld;
   logic [255:0] b_core_key;
   logic [127:0] b_core_text;
   logic         b_core_done;
   logic [127:0] b_core_text_out;
   logic         b_out_valid;
   logic         b_out_ready = 1'b0;
   logic [31:0]  b_out_data;
   logic         b_out_last;
   logic         b_busy;
   logic [2:0]   b_pipe = '0;
   logic [127:0] b_res = '0;
`ifdef AES_ADAPT_KEY_CACHE_EN
   logic         b_key_reload = 1'b1;
`endif

   aes_stream_adapter #(.WORD_W(32), .KEY_W(256)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (b_in_valid),
      .in_ready      (b_in_ready),
      .in_key        (b_in_key),
      .in_text       (b_in_text),
      .core_ld       (b_core_ld),
      .core_key      (b_core_key),
      .core_text     (b_core_text),
      .core_done     (b_core_done),
      .core_text_out (b_core_text_out),
      .out_valid     (b_out_valid),
      .out_ready     (b_out_ready),
      .out_data      (b_out_data),
      .out_last      (b_out_last),
      .busy          (b_busy)
`ifdef AES_ADAPT_KEY_CACHE_EN
      ,
      .key_reload    (b_key_reload)
`endif
   );

   always @(posedge clk) begin
      b_pipe <= {b_pipe[1:0], b_core_ld};
      if (b_core_ld) b_res <= (b_core_key == K256 && b_core_text == PT) ? C256 : BADC;
   end
   assign b_core_done     = b_pipe[2];
   assign b_core_text_out = b_res;

   // ---------------- helpers
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic a_beat(input logic [31:0] k, input logic [31:0] t);
      int n;
      n = 0;
      a_in_valid = 1'b1;
      a_in_key   = k;
      a_in_text  = t;
      @(negedge clk);
      while (!a_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!a_in_ready) check("a_in_ready_timeout", a_in_ready, 1);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      a_in_key   = '0;
      a_in_text  = '0;
   endtask

   // Sends a 4-beat block, checks the load cycle, returns one cycle after it.
   task automatic a_block(input logic [127:0] key, input logic [127:0] text,
                          input int gap_max, input bit spur_ld);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
         end
         a_beat(key[127-32*i -: 32], text[127-32*i -: 32]);
      end
      check("a_core_ld_pulse", a_core_ld, 1);
      check("a_core_key", a_core_key, key);
      check("a_core_text", a_core_text, text);
      check("a_in_ready_ld", a_in_ready, 0);
      if (spur_ld) a_spur = 1'b1;
      @(posedge clk);
      #1;
      a_spur = 1'b0;
      check("a_core_ld_one_cycle", a_core_ld, 0);
   endtask

   task automatic a_collect(input logic [127:0] exp, input int hold, input int exp_lat,
                            input int nbeats);
      int n;
      a_out_ready = (hold == 0);
      @(negedge clk);
      n = 1;
      while (!a_out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_out_valid_rise", a_out_valid, 1);
      if (exp_lat >= 0) check("a_latency", n, exp_lat);
      if (hold > 0) begin
         a_in_valid = 1'b1;
         a_in_key   = 32'hffff_ffff;
         a_in_text  = 32'hffff_ffff;
      end
      for (int c = 0; c < hold; c++) begin
         check("a_hold_data", a_out_data, exp[127:96]);
         check("a_hold_last", a_out_last, 0);
         check("a_hold_in_ready", a_in_ready, 0);
         @(negedge clk);
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("a_out_valid%0d", i), a_out_valid, 1);
         check($sformatf("a_out_data%0d", i), a_out_data, exp[127-32*i -: 32]);
         check($sformatf("a_out_last%0d", i), a_out_last, (i == 3));
         @(posedge clk);
         #1;
      end
      a_out_ready = 1'b0;
   endtask

   task automatic a_post(input logic [127:0] key);
      check("a_post_out_valid", a_out_valid, 0);
      check("a_post_in_ready", a_in_ready, 1);
      check("a_post_busy", a_busy, 0);
      check("a_post_key_held", a_core_key, key);
   endtask

   task automatic b_beat(input logic [31:0] k, input logic [31:0] t);
      int n;
      n = 0;
      b_in_valid = 1'b1;
      b_in_key   = k;
      b_in_text  = t;
      @(negedge clk);
      while (!b_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!b_in_ready) check("b_in_ready_timeout", b_in_ready, 1);
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
   endtask

   task automatic b_block(input logic [255:0] key, input logic [127:0] text, input int nbeats);
      logic [31:0] t;
      for (int i = 0; i < nbeats; i++) begin
         if (i < 4) t = text[127-32*i -: 32];
         else       t = 32'hdead_0000 + 32'(i);
         b_beat(key[255-32*i -: 32], t);
      end
   endtask

   task automatic b_collect(input logic [127:0] exp);
      int n;
      n = 0;
      b_out_ready = 1'b1;
      @(negedge clk);
      while (!b_out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("b_out_valid_rise", b_out_valid, 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("b_out_data%0d", i), b_out_data, exp[127-32*i -: 32]);
         check($sformatf("b_out_last%0d", i), b_out_last, (i == 3));
         @(posedge clk);
         #1;
      end
      b_out_ready = 1'b0;
      check("b_post_in_ready", b_in_ready, 1);
      check("b_post_busy", b_busy, 0);
   endtask

   // ---------------- directed sequence
   initial begin
      #1 rst = 1'b1;
      #1;
      check("rst_in_ready", a_in_ready, 1);
      check("rst_core_ld", a_core_ld, 0);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_last", a_out_last, 0);
      check("rst_busy", a_busy, 0);
      check("rst_out_data", a_out_data, 0);
      check("rst_core_key", a_core_key, 0);
      check("rst_core_text", a_core_text, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // spurious done while filling
      a_spur = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      a_spur = 1'b0;
      check("spur_fill_out_valid", a_out_valid, 0);
      check("spur_fill_busy", a_busy, 0);
      check("spur_fill_in_ready", a_in_ready, 1);

      // basic block, with a spurious done coincident with core_ld
      a_block(K128, PT, 0, 1'b1);
      check("wait_busy", a_busy, 1);
      a_collect(C128, 0, 4, 4);
      a_post(K128);

      // backpressure with random input gaps
      a_block(K128, PT, 2, 1'b0);
      a_collect(C128, 5, -1, 4);
      a_post(K128);

      // reset after two output beats
      a_block(K128, PT, 0, 1'b0);
      a_collect(C128, 0, -1, 2);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", a_out_valid, 0);
      check("midrst_busy", a_busy, 0);
      check("midrst_in_ready", a_in_ready, 1);
      check("midrst_out_data", a_out_data, 0);
      check("midrst_core_key", a_core_key, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      a_block(K128, PT, 1, 1'b0);
      a_collect(C128, 0, 4, 4);
      a_post(K128);

      // 256-bit key, garbage text on beats 5-8
      b_block(K256, PT, 8);
      check("b_core_ld", b_core_ld, 1);
      check("b_core_key", b_core_key, K256);
      check("b_core_text", b_core_text, PT);
      b_collect(C256);

`ifdef AES_ADAPT_KEY_CACHE_EN
      // cached key: 4 beats, in_key ignored
      b_key_reload = 1'b0;
      b_block({256{1'b1}}, PT, 4);
      b_key_reload = 1'b1;
      check("cache_core_ld", b_core_ld, 1);
      check("cache_core_key", b_core_key, K256);
      check("cache_core_text", b_core_text, PT);
      b_collect(C256);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
